// File: rtl/modulation_sampler_sync.sv
// rtl/modulation_sampler_sync.sv - phase-aligned modulation buffer index tracked from system time
//
// Produces IDX = floor(SYS_TIME / FREQ_DIV) mod (CYCLE + 1). After a sequential
// initialisation (two restoring divisions), IDX is advanced incrementally.
// SYS_TIME discontinuities are detected and trigger a resync.
//
// Ports:
//   CLK        - system clock
//   RST        - synchronous active-high reset
//   SYS_TIME   - free-running system time, advances by TIME_STEP per edge
//   CYCLE      - last index; the period is CYCLE+1 entries
//   FREQ_DIV   - SYS_TIME ticks per index step
//   UPDATE     - pulse: re-latch configuration and resync
//   IDX        - current modulation index
//   VALID      - IDX is synchronised to SYS_TIME
//   IDX_STROBE - one-cycle pulse after each edge that loads or advances IDX
//   SYNC_ERR   - one-cycle pulse after a SYS_TIME discontinuity
//   CFG_ERR    - latched configuration is illegal (FREQ_DIV < TIME_STEP)
module modulation_sampler_sync #(
  parameter int TIME_W    = 64,
  parameter int IDX_W     = 16,
  parameter int DIV_W     = 32,
  parameter int TIME_STEP = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [TIME_W-1:0] SYS_TIME,
  input  logic [IDX_W-1:0]  CYCLE,
  input  logic [DIV_W-1:0]  FREQ_DIV,
  input  logic              UPDATE,
  output logic [IDX_W-1:0]  IDX,
  output logic              VALID,
  output logic              IDX_STROBE,
  output logic              SYNC_ERR,
  output logic              CFG_ERR
);

  localparam int INIT_LAT = 2 * TIME_W + 1;
  localparam int CNT_W    = $clog2(TIME_W);

  // SYS_TIME will have advanced by this much when the LOAD edge arrives.
  localparam logic [TIME_W-1:0] LEAD    = TIME_W'(TIME_STEP * INIT_LAT);
  localparam logic [TIME_W-1:0] STEP_T  = TIME_W'(TIME_STEP);
  localparam logic [DIV_W:0]    STEP_D  = (DIV_W + 1)'(TIME_STEP);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]    QD_ONE  = (IDX_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(TIME_W - 1);

  typedef enum logic [2:0] {S_LATCH, S_DIV_T, S_DIV_Q, S_LOAD, S_RUN, S_ERR} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cyc;
  logic [DIV_W-1:0]   div;
  logic [TIME_W-1:0]  t0;
  logic [TIME_W-1:0]  exp_t;
  logic [TIME_W-1:0]  shreg;   // dividend shifting out MSB first; holds q after DIV_T
  logic [DIV_W:0]     rem;     // partial remainder in DIV_T, running remainder in RUN
  logic [IDX_W:0]     pr_q;    // partial remainder of q / (cyc+1)
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q, strobe_q, sync_err_q, cfg_err_q;

  logic               restart, cfg_bad, cnt_last, time_ok;
  logic [TIME_W-1:0]  t0_next;
  logic [DIV_W:0]     div_ext, t_cand, run_sum;
  logic [DIV_W-1:0]   t_diff;
  logic               t_ge, q_ge, run_adv;
  logic [IDX_W:0]     q_div, q_diff;
  logic [IDX_W+1:0]   q_cand;
  logic [IDX_W-1:0]   idx_inc;

  always_comb begin
    restart  = UPDATE || (state == S_LATCH);
    cfg_bad  = {1'b0, FREQ_DIV} < STEP_D;
    t0_next  = SYS_TIME + LEAD;
    cnt_last = (cnt == CNT_END);
    time_ok  = (SYS_TIME == exp_t);
    div_ext  = {1'b0, div};
    // Time division step; a successful subtraction always fits in DIV_W bits.
    t_cand   = {rem[DIV_W-1:0], shreg[TIME_W-1]};
    t_ge     = t_cand >= div_ext;
    t_diff   = t_cand[DIV_W-1:0] - div;
    // Index division step; divisor cyc+1 may reach 2^IDX_W.
    q_div    = {1'b0, cyc} + QD_ONE;
    q_cand   = {pr_q, shreg[TIME_W-1]};
    q_ge     = q_cand >= {1'b0, q_div};
    q_diff   = q_cand[IDX_W:0] - q_div;
    // div >= TIME_STEP bounds the sum below 2*div, so at most one advance.
    run_sum  = rem + STEP_D;
    run_adv  = run_sum >= div_ext;
    idx_inc  = (idx_q == cyc) ? '0 : idx_q + IDX_ONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_LATCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = cfg_bad ? S_ERR : S_DIV_T;
    end else begin
      case (state)
        S_DIV_T: if (cnt_last) state_nxt = S_DIV_Q;
        S_DIV_Q: if (cnt_last) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_RUN;
        S_RUN:   if (!time_ok) state_nxt = S_LATCH;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc        <= '0;
      div        <= '0;
      t0         <= '0;
      exp_t      <= '0;
      shreg      <= '0;
      rem        <= '0;
      pr_q       <= '0;
      cnt        <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      sync_err_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      strobe_q   <= 1'b0;
      sync_err_q <= 1'b0;
      if (restart) begin
        cyc       <= CYCLE;
        div       <= FREQ_DIV;
        t0        <= t0_next;
        shreg     <= t0_next;
        rem       <= '0;
        pr_q      <= '0;
        cnt       <= '0;
        valid_q   <= 1'b0;
        cfg_err_q <= cfg_bad;
      end else begin
        case (state)
          S_DIV_T: begin
            shreg <= {shreg[TIME_W-2:0], t_ge};
            rem   <= t_ge ? {1'b0, t_diff} : t_cand;
            cnt   <= cnt_last ? '0 : cnt + CNT_ONE;
          end
          S_DIV_Q: begin
            shreg <= {shreg[TIME_W-2:0], 1'b0};
            pr_q  <= q_ge ? q_diff : q_cand[IDX_W:0];
            cnt   <= cnt_last ? '0 : cnt + CNT_ONE;
          end
          S_LOAD: begin
            idx_q    <= pr_q[IDX_W-1:0];
            exp_t    <= t0 + STEP_T;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
          end
          S_RUN: begin
            if (!time_ok) begin
              sync_err_q <= 1'b1;
              valid_q    <= 1'b0;
            end else begin
              exp_t <= exp_t + STEP_T;
              if (run_adv) begin
                rem      <= run_sum - div_ext;
                idx_q    <= idx_inc;
                strobe_q <= 1'b1;
              end else begin
                rem <= run_sum;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    IDX        = idx_q;
    VALID      = valid_q;
    IDX_STROBE = strobe_q;
    SYNC_ERR   = sync_err_q;
    CFG_ERR    = cfg_err_q;
  end

endmodule

// File: tb/tb_modulation_sampler_sync.sv
// tb/tb_modulation_sampler_sync.sv - directed bench for modulation_sampler_sync
module tb_modulation_sampler_sync;

  localparam int INIT_LAT = 129;

  logic        clk;
  logic        rst;
  logic [63:0] sys_time;
  logic [15:0] cycle;
  logic [31:0] freq_div;
  logic        update;
  logic [15:0] idx;
  logic        valid;
  logic        idx_strobe;
  logic        sync_err;
  logic        cfg_err;

  int          n_checks;
  int          n_errors;
  logic [63:0] st;   // value SYS_TIME presents at the next edge
  logic [63:0] ts;   // value sampled at the most recent edge
  logic [63:0] dv;   // bench copy of configured FREQ_DIV
  logic [63:0] cy;   // bench copy of configured CYCLE

  modulation_sampler_sync dut (
    .CLK        (clk),
    .RST        (rst),
    .SYS_TIME   (sys_time),
    .CYCLE      (cycle),
    .FREQ_DIV   (freq_div),
    .UPDATE     (update),
    .IDX        (idx),
    .VALID      (valid),
    .IDX_STROBE (idx_strobe),
    .SYNC_ERR   (sync_err),
    .CFG_ERR    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    ts = st;
    @(posedge clk);
    #1;
    st = st + 64'd8;
    sys_time = st;
  endtask

  function automatic logic [63:0] model_idx(input logic [63:0] t);
    return (t / dv) % (cy + 64'd1);
  endfunction

  // Next edge must be a LATCH or UPDATE edge; walks the full init sequence.
  task automatic sync_check(input string tag);
    logic [63:0] held;
    held = 64'(idx);
    tick();
    update = 1'b0;
    check_eq({tag, ".hold_idx"}, 64'(idx), held);
    check_eq({tag, ".latch_valid"}, 64'(valid), 64'd0);
    check_eq({tag, ".latch_sync"}, 64'(sync_err), 64'd0);
    check_eq({tag, ".latch_cfg"}, 64'(cfg_err), 64'd0);
    for (int i = 1; i < INIT_LAT; i++) tick();
    check_eq({tag, ".valid_early"}, 64'(valid), 64'd0);
    tick();
    check_eq({tag, ".valid_rise"}, 64'(valid), 64'd1);
    check_eq({tag, ".first_idx"}, 64'(idx), model_idx(ts));
    check_eq({tag, ".load_strobe"}, 64'(idx_strobe), 64'd1);
  endtask

  task automatic run_check(input string tag, input int n);
    logic [63:0] adv;
    for (int i = 0; i < n; i++) begin
      tick();
      adv = ((ts / dv) != ((ts - 64'd8) / dv)) ? 64'd1 : 64'd0;
      check_eq({tag, ".idx"}, 64'(idx), model_idx(ts));
      check_eq({tag, ".strobe"}, 64'(idx_strobe), adv);
      check_eq({tag, ".valid"}, 64'(valid), 64'd1);
      check_eq({tag, ".sync"}, 64'(sync_err), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] held;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    update   = 1'b0;
    st       = 64'd0;
    sys_time = 64'd0;
    freq_div = 32'd4096;
    cycle    = 16'hFFFF;
    dv       = 64'd4096;
    cy       = 64'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.idx", 64'(idx), 64'd0);
    check_eq("rst.valid", 64'(valid), 64'd0);
    check_eq("rst.strobe", 64'(idx_strobe), 64'd0);
    check_eq("rst.sync", 64'(sync_err), 64'd0);
    check_eq("rst.cfg", 64'(cfg_err), 64'd0);
    rst = 1'b0;

    // Defaults from SYS_TIME 0: VALID at LATCH edge + 129.
    sync_check("dflt");
    run_check("dflt", 1100);

    // Discontinuity: +1000 jump while running.
    st = st + 64'd1000;
    sys_time = st;
    held = 64'(idx);
    tick();
    check_eq("jump.sync_pulse", 64'(sync_err), 64'd1);
    check_eq("jump.valid", 64'(valid), 64'd0);
    check_eq("jump.strobe", 64'(idx_strobe), 64'd0);
    check_eq("jump.hold_idx", 64'(idx), held);
    sync_check("jump");
    run_check("jump", 600);

    // UPDATE mid-RUN with preset time base and odd divider.
    st = 64'h0000_0123_4567_89AB;
    sys_time = st;
    freq_div = 32'd4100;
    cycle = 16'd999;
    dv = 64'd4100;
    cy = 64'd999;
    update = 1'b1;
    sync_check("preset");
    run_check("preset", 1500);

    // Short period; configuration inputs changed afterwards must be ignored.
    freq_div = 32'd40;
    cycle = 16'd4;
    dv = 64'd40;
    cy = 64'd4;
    update = 1'b1;
    sync_check("cyc4");
    freq_div = 32'd12345;
    cycle = 16'd7;
    run_check("cyc4", 60);

    // Boundary: FREQ_DIV equal to TIME_STEP advances on every edge.
    freq_div = 32'd8;
    cycle = 16'd2;
    dv = 64'd8;
    cy = 64'd2;
    update = 1'b1;
    sync_check("div8");
    run_check("div8", 12);

    // Illegal configuration: just below TIME_STEP, then FREQ_DIV=4.
    held = 64'(idx);
    freq_div = 32'd7;
    update = 1'b1;
    tick();
    update = 1'b0;
    check_eq("cfg7.cfg_err", 64'(cfg_err), 64'd1);
    check_eq("cfg7.valid", 64'(valid), 64'd0);
    check_eq("cfg7.hold_idx", 64'(idx), held);
    repeat (10) tick();
    check_eq("cfg7.cfg_stays", 64'(cfg_err), 64'd1);
    check_eq("cfg7.valid_stays", 64'(valid), 64'd0);
    check_eq("cfg7.strobe", 64'(idx_strobe), 64'd0);
    freq_div = 32'd4;
    update = 1'b1;
    tick();
    update = 1'b0;
    check_eq("cfg4.cfg_err", 64'(cfg_err), 64'd1);
    check_eq("cfg4.valid", 64'(valid), 64'd0);
    freq_div = 32'd4096;
    cycle = 16'hFFFF;
    dv = 64'd4096;
    cy = 64'hFFFF;
    update = 1'b1;
    sync_check("cfg_fix");
    run_check("cfg_fix", 300);

    // Reset in the middle of the time division.
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check_eq("rstmid.idx", 64'(idx), 64'd0);
    check_eq("rstmid.valid", 64'(valid), 64'd0);
    check_eq("rstmid.strobe", 64'(idx_strobe), 64'd0);
    check_eq("rstmid.sync", 64'(sync_err), 64'd0);
    check_eq("rstmid.cfg", 64'(cfg_err), 64'd0);
    rst = 1'b0;
    sync_check("rstmid");
    run_check("rstmid", 100);

    // SYS_TIME rollover: not a discontinuity, index keeps counting.
    st = 64'hFFFF_FFFF_FFFF_FFFF - 64'd1431;
    sys_time = st;
    update = 1'b1;
    sync_check("wrap");
    run_check("wrap", 200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
